float_mul_iter: RTL

Parametrised, multi-cycle IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides. It computes the product with a radix-2 shift-add datapath, then normalises and rounds to nearest-even. It handles zero, infinity and NaN operands, and reports exception flags. It is the sequential, configurable successor to the single-cycle `mulf` multiplier in the float ALU path, and it carries a single operation at a time.

---
 rtl/float_mul_iter.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/float_mul_iter.sv
// float_mul_iter: multi-cycle floating-point multiplier with valid/ready
// handshakes on both sides. Operands are {sign, exp, mantissa}. The
// significand product is built by a radix-2 shift-add loop that consumes one
// multiplier bit per cycle. The product is then normalised and rounded to
// nearest-even. Subnormal operands are flushed to signed zero. NaN and
// infinity operands bypass the datapath. Only one operation is in flight.
//
// Parameters:
//   EW        exponent width (bias = 2^(EW-1)-1)
//   MW        stored mantissa width, word width W = 1+EW+MW
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset, aborts any operation
//   in_valid  operands valid
//   in_ready  high only while idle
//   a, b      operands
//   out_valid result valid, held until out_ready
//   out_ready consumer accepts the result
//   s         product
//   flags     {invalid, overflow, underflow, inexact}, valid with out_valid
module float_mul_iter #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW+MW:0]  a,
    input  logic [EW+MW:0]  b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EW+MW:0]  s,
    output logic [3:0]      flags
);

    localparam int W  = 1 + EW + MW;
    localparam int PW = 2 * MW + 2;
    localparam int CW = $clog2(MW + 2);

    localparam logic signed [EW+1:0] BIAS    = {3'b000, {(EW-1){1'b1}}};
    localparam logic signed [EW+1:0] EXP_MAX = {2'b00, {EW{1'b1}}};
    localparam logic signed [EW+1:0] EXP_ONE = {{(EW+1){1'b0}}, 1'b1};
    localparam logic signed [EW+1:0] EXP_ZERO = {(EW+2){1'b0}};
    localparam logic [CW-1:0]        CNT_LAST = CW'(MW);
    localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]         QNAN =
        {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [W-1:0]           a_r;
    logic [W-1:0]           b_r;
    logic [PW-1:0]          prod_r;
    logic [CW-1:0]          cnt_r;
    logic signed [EW+1:0]   exp_r;
    logic [W-1:0]           s_r;
    logic [3:0]             flags_r;
    logic                   out_valid_r;

    // Operand field decode of the latched operands
    logic [EW-1:0] a_exp_s, b_exp_s;
    logic [MW-1:0] a_man_s, b_man_s;
    logic          a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic          a_snan_s, b_snan_s, sign_s;

    assign a_exp_s  = a_r[W-2:MW];
    assign b_exp_s  = b_r[W-2:MW];
    assign a_man_s  = a_r[MW-1:0];
    assign b_man_s  = b_r[MW-1:0];
    assign a_zero_s = (a_exp_s == {EW{1'b0}});
    assign b_zero_s = (b_exp_s == {EW{1'b0}});
    assign a_inf_s  = (a_exp_s == {EW{1'b1}}) && (a_man_s == {MW{1'b0}});
    assign b_inf_s  = (b_exp_s == {EW{1'b1}}) && (b_man_s == {MW{1'b0}});
    assign a_nan_s  = (a_exp_s == {EW{1'b1}}) && (a_man_s != {MW{1'b0}});
    assign b_nan_s  = (b_exp_s == {EW{1'b1}}) && (b_man_s != {MW{1'b0}});
    assign a_snan_s = a_nan_s && !a_man_s[MW-1];
    assign b_snan_s = b_nan_s && !b_man_s[MW-1];
    assign sign_s   = a_r[W-1] ^ b_r[W-1];

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign flags     = flags_r;

    logic           spec_hit_s;
    logic [W-1:0]   spec_res_s;
    logic           spec_inv_s;

    // Special-operand classification; NaN outranks inf*zero, which outranks inf and zero
    always_comb begin
        spec_hit_s = 1'b1;
        spec_res_s = {W{1'b0}};
        spec_inv_s = 1'b0;
        if (a_nan_s || b_nan_s) begin
            spec_res_s = QNAN;
            spec_inv_s = a_snan_s || b_snan_s;
        end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            spec_res_s = QNAN;
            spec_inv_s = 1'b1;
        end else if (a_inf_s || b_inf_s) begin
            spec_res_s = {sign_s, {EW{1'b1}}, {MW{1'b0}}};
        end else if (a_zero_s || b_zero_s) begin
            spec_res_s = {sign_s, {(W-1){1'b0}}};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // One shift-add step: the upper half accumulates the multiplicand when the
    // multiplier LSB (low half of prod_r) is set, then the pair shifts right
    logic [MW+1:0]          add_s;
    logic [PW-1:0]          step_s;
    logic signed [EW+1:0]   exp_sum_s;

    assign add_s     = {1'b0, prod_r[PW-1:MW+1]} + {1'b0, 1'b1, a_man_s};
    assign exp_sum_s = $signed({2'b00, a_exp_s}) + $signed({2'b00, b_exp_s}) - BIAS;

    // Multiply step selection
    always_comb begin
        if (prod_r[0]) begin
            step_s = {add_s, prod_r[MW:1]};
        end else begin
            step_s = {1'b0, prod_r[PW-1:1]};
        end
    end

    // Rounding of the normalised product (leading one at bit 2MW)
    logic [MW-1:0]          kept_s;
    logic                   guard_s, sticky_s, inc_s;
    logic [MW+1:0]          sig_s;
    logic [MW-1:0]          mant_s;
    logic signed [EW+1:0]   fexp_s;
    logic [W-1:0]           rnd_res_s;
    logic [3:0]             rnd_flags_s;

    assign kept_s   = prod_r[2*MW-1:MW];
    assign guard_s  = prod_r[MW-1];
    assign sticky_s = |prod_r[MW-2:0];
    assign inc_s    = guard_s && (sticky_s || kept_s[0]);
    assign sig_s    = {2'b01, kept_s} + {{(MW+1){1'b0}}, inc_s};
    assign fexp_s   = exp_r + $signed({{(EW+1){1'b0}}, sig_s[MW+1]});

    // Final packing with overflow/underflow saturation
    always_comb begin
        if (sig_s[MW+1]) begin
            mant_s = sig_s[MW:1];
        end else begin
            mant_s = sig_s[MW-1:0];
        end
        if (fexp_s >= EXP_MAX) begin
            rnd_res_s   = {sign_s, {EW{1'b1}}, {MW{1'b0}}};
            rnd_flags_s = 4'b0101;
        end else if (fexp_s <= EXP_ZERO) begin
            rnd_res_s   = {sign_s, {(W-1){1'b0}}};
            rnd_flags_s = 4'b0011;
        end else begin
            rnd_res_s   = {sign_s, fexp_s[EW-1:0], mant_s};
            rnd_flags_s = {3'b000, guard_s || sticky_s};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (spec_hit_s) begin
                    state_nx_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_NORM;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            ST_NORM:  state_nx_s = ST_ROUND;
            ST_ROUND: state_nx_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            prod_r      <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            exp_r       <= EXP_ZERO;
            s_r         <= {W{1'b0}};
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        // multiplier significand sits in the low half
                        prod_r <= {{(MW+1){1'b0}}, 1'b1, b[MW-1:0]};
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                ST_MUL: begin
                    exp_r <= exp_sum_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (spec_hit_s) begin
                        s_r         <= spec_res_s;
                        flags_r     <= {spec_inv_s, 3'b000};
                        out_valid_r <= 1'b1;
                    end else begin
                        prod_r <= step_s;
                    end
                end
                ST_NORM: begin
                    // the shifted-out bit is folded into bit 0 so it still counts as sticky
                    if (prod_r[PW-1]) begin
                        prod_r <= {1'b0, prod_r[PW-1:2], prod_r[1] | prod_r[0]};
                        exp_r  <= exp_r + EXP_ONE;
                    end
                end
                ST_ROUND: begin
                    s_r         <= rnd_res_s;
                    flags_r     <= rnd_flags_s;
                    out_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
